// File: rtl/lite_regfile_irq.sv
// Xillybus Lite register file: W1C interrupt pending word, interrupt enable word,
// read-only status words and byte-lane writable control words, with registered user_irq.

module lite_regfile_irq_word (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_we,
    input  logic [31:0] i_mask,
    input  logic [31:0] i_data,
    output logic [31:0] o_word
);
    logic [31:0] r_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_word <= '0;
        else if (i_we)
            r_word <= (r_word & ~i_mask) | (i_data & i_mask);
    end

    assign o_word = r_word;
endmodule

module lite_regfile_irq #(
    parameter  int ADDR_BITS = 5,
    parameter  int N_STATUS  = 4,
    parameter  int IRQ_BITS  = 8,
    localparam int NWORDS    = 2**ADDR_BITS
) (
    input  logic                     user_clk,
    input  logic                     user_rst_n,
    input  logic                     user_wren,
    input  logic [3:0]               user_wstrb,
    input  logic                     user_rden,
    input  logic [31:0]              user_addr,
    input  logic [31:0]              user_wr_data,
    output logic [31:0]              user_rd_data,
    output logic                     user_irq,
    input  logic [N_STATUS*32-1:0]   status_in,
    input  logic [IRQ_BITS-1:0]      irq_event,
    output logic [NWORDS*32-1:0]     ctrl_regs,
    output logic [NWORDS-1:0]        ctrl_wr
);
    localparam int CTRL0 = 2 + N_STATUS;

    logic [ADDR_BITS-1:0] w_waddr;
    logic [31:0]          w_bmask;
    logic                 w_wr;
    logic [NWORDS-1:0]    w_sel;
    logic [31:0]          w_word [NWORDS];
    logic [31:0]          w_pend32;
    logic [31:0]          w_en32;
    logic [IRQ_BITS-1:0]  w_pend_nxt;
    logic                 w_unused;

    logic [IRQ_BITS-1:0]  r_pend;
    logic [IRQ_BITS-1:0]  r_en;
    logic [31:0]          r_rd_data;
    logic                 r_irq;
    logic [NWORDS-1:0]    r_ctrl_wr;

    // Upper address bits and the byte offset deliberately alias onto the word map.
    assign w_waddr  = user_addr[ADDR_BITS+1:2];
    assign w_unused = ^{user_addr[31:ADDR_BITS+2], user_addr[1:0]};
    assign w_bmask  = {{8{user_wstrb[3]}}, {8{user_wstrb[2]}},
                       {8{user_wstrb[1]}}, {8{user_wstrb[0]}}};
    assign w_wr     = user_wren & (|user_wstrb);
    assign w_sel    = w_wr ? (NWORDS'(1) << w_waddr) : '0;

    always_comb begin
        w_pend32                 = '0;
        w_pend32[IRQ_BITS-1:0]   = r_pend;
        w_en32                   = '0;
        w_en32[IRQ_BITS-1:0]     = r_en;
    end

    // A same-cycle event beats the W1C clear on the same bit.
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_sel[0])
            w_pend_nxt = r_pend & ~(user_wr_data[IRQ_BITS-1:0] & w_bmask[IRQ_BITS-1:0]);
        w_pend_nxt = w_pend_nxt | irq_event;
    end

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            r_pend <= '0;
            r_en   <= '0;
            r_irq  <= 1'b0;
        end else begin
            r_pend <= w_pend_nxt;
            if (w_sel[1])
                r_en <= (r_en & ~w_bmask[IRQ_BITS-1:0])
                      | (user_wr_data[IRQ_BITS-1:0] & w_bmask[IRQ_BITS-1:0]);
            r_irq  <= |(r_pend & r_en);
        end
    end

    genvar k;
    generate
        for (k = 0; k < NWORDS; k++) begin : g_word
            if (k == 0) begin : g_pend
                assign w_word[k] = w_pend32;
            end else if (k == 1) begin : g_en
                assign w_word[k] = w_en32;
            end else if (k < CTRL0) begin : g_status
                assign w_word[k] = status_in[32*(k-2) +: 32];
            end else begin : g_ctrl
                lite_regfile_irq_word u_word (
                    .clk    (user_clk),
                    .rst_n  (user_rst_n),
                    .i_we   (w_sel[k]),
                    .i_mask (w_bmask),
                    .i_data (user_wr_data),
                    .o_word (w_word[k])
                );
            end
            assign ctrl_regs[32*k +: 32] = w_word[k];
        end
    endgenerate

    // Reads see the pre-write view, so a same-cycle read/write returns the old value.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            r_rd_data <= '0;
            r_ctrl_wr <= '0;
        end else begin
            if (user_rden)
                r_rd_data <= w_word[w_waddr];
            r_ctrl_wr <= w_sel;
        end
    end

    assign user_rd_data = r_rd_data;
    assign user_irq     = r_irq;
    assign ctrl_wr      = r_ctrl_wr;
endmodule

// File: tb/tb_lite_regfile_irq.sv
// Bench for lite_regfile_irq: fixed write/read vector table, hand-written interrupt and
// reset sequences, then random traffic checked against a word-level reference model.

module tb_lite_regfile_irq;
    localparam int AB = 5;
    localparam int NS = 1;
    localparam int IB = 8;
    localparam int NW = 32;
    localparam logic [31:0] IRQM = 32'h0000_00FF;

    logic             user_clk, user_rst_n;
    logic             wren, rden;
    logic [3:0]       wstrb;
    logic [31:0]      addr, wdata;
    logic [31:0]      rd_data;
    logic             irq;
    logic [NS*32-1:0] status;
    logic [IB-1:0]    ev;
    logic [NW*32-1:0] regs;
    logic [NW-1:0]    cwr;

    lite_regfile_irq #(.ADDR_BITS(AB), .N_STATUS(NS), .IRQ_BITS(IB)) dut (
        .user_clk     (user_clk),
        .user_rst_n   (user_rst_n),
        .user_wren    (wren),
        .user_wstrb   (wstrb),
        .user_rden    (rden),
        .user_addr    (addr),
        .user_wr_data (wdata),
        .user_rd_data (rd_data),
        .user_irq     (irq),
        .status_in    (status),
        .irq_event    (ev),
        .ctrl_regs    (regs),
        .ctrl_wr      (cwr)
    );

    initial user_clk = 1'b0;
    always #5 user_clk = ~user_clk;

    int checks = 0;
    int failures = 0;

    // Reference model: the register map as plain words.
    logic [31:0] m_mem [NW];
    logic [31:0] m_pend, m_en, m_rd, m_cwr;
    logic        m_irq;

    task automatic model_reset();
        for (int i = 0; i < NW; i++) m_mem[i] = '0;
        m_pend = '0; m_en = '0; m_rd = '0; m_cwr = '0; m_irq = 1'b0;
    endtask

    function automatic logic [31:0] model_word(input int k);
        if (k == 0)           return m_pend;
        else if (k == 1)      return m_en;
        else if (k < 2 + NS)  return status[32*(k-2) +: 32];
        else                  return m_mem[k];
    endfunction

    function automatic logic [NW*32-1:0] exp_regs();
        logic [NW*32-1:0] r;
        for (int k = 0; k < NW; k++) r[32*k +: 32] = model_word(k);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk_regs(input string nm, input logic [NW*32-1:0] exp);
        checks++;
        for (int k = 0; k < NW; k++) begin
            if (regs[32*k +: 32] !== exp[32*k +: 32]) begin
                failures++;
                $display("FAIL %s word %0d actual=%h required=%h", nm, k,
                         regs[32*k +: 32], exp[32*k +: 32]);
                break;
            end
        end
    endtask

    task automatic drive(input logic we, input logic [3:0] sb, input logic re,
                         input logic [31:0] a, input logic [31:0] d, input logic [IB-1:0] e);
        wren = we; wstrb = sb; rden = re; addr = a; wdata = d; ev = e;
    endtask

    // Advance one clock, updating the model from the inputs applied during that cycle.
    task automatic step();
        logic [31:0] m, nrd, npend, nen, ncwr;
        logic        nirq;
        int          k;
        m     = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
        k     = int'(addr[6:2]);
        nrd   = rden ? model_word(k) : m_rd;
        nirq  = |(m_pend & m_en);
        ncwr  = (wren && wstrb != 4'h0) ? (32'h1 << k) : 32'h0;
        npend = m_pend;
        nen   = m_en;
        if (wren) begin
            if (k == 0)           npend = m_pend & ~(wdata & m);
            else if (k == 1)      nen = ((m_en & ~m) | (wdata & m)) & IRQM;
            else if (k >= 2 + NS) m_mem[k] = (m_mem[k] & ~m) | (wdata & m);
        end
        npend = (npend | 32'(ev)) & IRQM;
        @(posedge user_clk); #1;
        m_rd = nrd; m_irq = nirq; m_cwr = ncwr; m_pend = npend; m_en = nen;
    endtask

    typedef struct {
        logic [31:0] waddr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] raddr;
        logic [31:0] exp_rd;
        logic [31:0] exp_wr;
    } vec_t;

    vec_t tbl [8];

    initial begin
        tbl[0] = '{32'h0000_0020, 4'b0101, 32'hAABB_CCDD, 32'h0000_0020, 32'h00BB_00DD, 32'h0000_0100};
        tbl[1] = '{32'h0000_0008, 4'b1111, 32'h1234_5678, 32'h0000_0008, 32'hCAFE_F00D, 32'h0000_0004};
        tbl[2] = '{32'h0000_008C, 4'b1111, 32'h1122_3344, 32'h0000_000C, 32'h1122_3344, 32'h0000_0008};
        tbl[3] = '{32'h0000_000F, 4'b1000, 32'hFF00_0000, 32'hFFFF_FF8C, 32'hFF22_3344, 32'h0000_0008};
        tbl[4] = '{32'h0000_0004, 4'b1111, 32'hFFFF_FFFF, 32'h0000_0004, 32'h0000_00FF, 32'h0000_0002};
        tbl[5] = '{32'h0000_0005, 4'b0001, 32'h0000_0000, 32'h0000_0007, 32'h0000_0000, 32'h0000_0002};
        tbl[6] = '{32'h0000_0020, 4'b0000, 32'hFFFF_FFFF, 32'h0000_0021, 32'h00BB_00DD, 32'h0000_0000};
        tbl[7] = '{32'h0000_007C, 4'b1100, 32'hDEAD_BEEF, 32'h0000_007C, 32'hDEAD_0000, 32'h8000_0000};

        user_rst_n = 1'b0;
        status = 32'hCAFE_F00D;
        drive(1'b0, 4'h0, 1'b0, 32'h0, 32'h0, '0);
        model_reset();
        repeat (3) @(posedge user_clk);
        #1;
        chk("reset_rd", rd_data, 32'h0);
        chk("reset_irq", {31'h0, irq}, 32'h0);
        chk("reset_ctrl_wr", cwr, 32'h0);
        chk("reset_word8", regs[32*8 +: 32], 32'h0);
        #4 user_rst_n = 1'b1;

        // Vector table: write, check pulse, read back, check pulse gone.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, tbl[i].strb, 1'b0, tbl[i].waddr, tbl[i].wdata, '0);
            step();
            chk($sformatf("tbl%0d_ctrl_wr", i), cwr, tbl[i].exp_wr);
            drive(1'b0, 4'h0, 1'b1, tbl[i].raddr, 32'h0, '0);
            step();
            chk($sformatf("tbl%0d_rd", i), rd_data, tbl[i].exp_rd);
            chk($sformatf("tbl%0d_pulse_end", i), cwr, 32'h0);
        end
        drive(1'b0, 4'h0, 1'b0, 32'h0, 32'h0, '0);
        step();
        chk("rd_held", rd_data, 32'hDEAD_0000);
        chk("status_mirror", regs[32*2 +: 32], 32'hCAFE_F00D);

        // Interrupt latency and W1C drop.
        drive(1'b1, 4'h1, 1'b0, 32'h4, 32'h1, '0); step();
        drive(1'b0, 4'h0, 1'b0, 32'h0, 32'h0, 8'h01); step();
        chk("irq_pend_n1", regs[31:0], 32'h1);
        chk("irq_n1", {31'h0, irq}, 32'h0);
        drive(1'b0, 4'h0, 1'b0, 32'h0, 32'h0, '0); step();
        chk("irq_n2", {31'h0, irq}, 32'h1);
        drive(1'b1, 4'h1, 1'b0, 32'h0, 32'h1, '0); step();
        chk("w1c_pend", regs[31:0], 32'h0);
        chk("w1c_irq_lag", {31'h0, irq}, 32'h1);
        drive(1'b0, 4'h0, 1'b0, 32'h0, 32'h0, '0); step();
        chk("w1c_irq_drop", {31'h0, irq}, 32'h0);

        // Set beats clear; disabled source stays quiet.
        drive(1'b1, 4'h1, 1'b0, 32'h0, 32'h8, 8'h08); step();
        chk("set_wins", regs[31:0], 32'h8);
        drive(1'b0, 4'h0, 1'b0, 32'h0, 32'h0, 8'h20); step();
        drive(1'b0, 4'h0, 1'b0, 32'h0, 32'h0, '0); step(); step();
        chk("disabled_pend", regs[31:0], 32'h28);
        chk("disabled_irq", {31'h0, irq}, 32'h0);
        drive(1'b1, 4'hF, 1'b0, 32'h0, 32'hFFFF_FFFF, '0); step();
        chk("w1c_all", regs[31:0], 32'h0);

        // Asynchronous reset during a write with user_irq high.
        drive(1'b0, 4'h0, 1'b0, 32'h0, 32'h0, 8'h01); step();
        drive(1'b0, 4'h0, 1'b1, 32'h20, 32'h0, '0); step(); step();
        chk("pre_reset_irq", {31'h0, irq}, 32'h1);
        drive(1'b1, 4'hF, 1'b0, 32'h20, 32'hFFFF_FFFF, '0);
        #3 user_rst_n = 1'b0;
        #1;
        chk("async_irq", {31'h0, irq}, 32'h0);
        chk("async_rd", rd_data, 32'h0);
        chk("async_ctrl_wr", cwr, 32'h0);
        chk("async_word8", regs[32*8 +: 32], 32'h0);
        chk("async_en", regs[63:32], 32'h0);
        @(posedge user_clk); #1;
        drive(1'b0, 4'h0, 1'b0, 32'h0, 32'h0, 8'hFF);
        @(posedge user_clk); #1;
        drive(1'b0, 4'h0, 1'b0, 32'h0, 32'h0, '0);
        user_rst_n = 1'b1;
        model_reset();
        drive(1'b0, 4'h0, 1'b1, 32'h20, 32'h0, '0); step();
        chk("post_reset_word8", rd_data, 32'h0);
        drive(1'b0, 4'h0, 1'b1, 32'h0, 32'h0, '0); step();
        chk("post_reset_pend", rd_data, 32'h0);
        drive(1'b0, 4'h0, 1'b1, 32'h8, 32'h0, '0); step();
        chk("post_reset_status", rd_data, 32'hCAFE_F00D);

        // Random traffic against the model.
        for (int n = 0; n < 500; n++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a[6:2] = 5'($urandom_range(0, 3));
            status = $urandom;
            drive(1'($urandom), 4'($urandom), 1'($urandom), a, $urandom,
                  ($urandom_range(0, 3) == 0) ? IB'($urandom) : '0);
            step();
            chk("rnd_rd", rd_data, m_rd);
            chk("rnd_irq", {31'h0, irq}, {31'h0, m_irq});
            chk("rnd_ctrl_wr", cwr, m_cwr);
            chk_regs("rnd_regs", exp_regs());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
